key_expand_ctrl: RTL

Sequential AES-128 key-expansion controller with a round-key store. It accepts a 128-bit cipher key over a valid/ready handshake and drives the existing one-round key schedule block (KeySchedule_top) once per clock for rounds 1–10. It stores all 11 round keys and serves them to the cipher datapath by round index. It sits directly upstream of KeySchedule_top, supplying `ip_key`, `enable` and `rndNo`, and directly downstream of it, consuming `op_key`.

---
 rtl/key_expand_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/key_expand_ctrl.sv
// key_expand_ctrl: sequential AES-128 key expansion with an 11-entry round-key store
//
// Ports (key_expand_ctrl):
//   clk         in   1    rising-edge clock
//   rst_n       in   1    asynchronous active-low reset
//   key_in      in   128  cipher key, [127:96] = w0 ... [31:0] = w3
//   key_valid   in   1    key_in valid this cycle
//   key_ready   out  1    a key can be accepted (IDLE or READY)
//   busy        out  1    expansion in progress
//   keys_valid  out  1    all 11 round keys stored
//   rk_idx      in   4    round-key read index, 0..10 (11..15 read as zero)
//   rk_out      out  128  registered round key, one cycle after rk_idx
//   zeroize     in   1    only when KEY_EXPAND_ZEROIZE_EN is defined: wipe store, return to IDLE
//
// KeySchedule_top: one combinational AES-128 key-schedule round (ip_key -> op_key for rndNo).
// Optional feature macro: KEY_EXPAND_ZEROIZE_EN.

module KeySchedule_top (
    input  logic [127:0] ip_key,
    input  logic         enable,
    input  logic [3:0]   rndNo,
    output logic [127:0] op_key
);
    localparam logic [7:0] RCON [0:10] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                          8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ x : p;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box computed as GF(2^8) inverse (a^254 = a^2*a^4*...*a^128) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] s;
        r = 8'h01;
        s = a;
        for (int i = 1; i < 8; i++) begin
            s = gmul(s, s);
            r = gmul(r, s);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    logic [31:0] w3_rot;
    logic [31:0] t;
    logic [31:0] o0, o1, o2, o3;
    logic [7:0]  rcon;

    always_comb begin
        rcon   = (rndNo > 4'd10) ? 8'h00 : RCON[rndNo];
        w3_rot = {ip_key[23:0], ip_key[31:24]};
        t      = {sbox(w3_rot[31:24]) ^ rcon, sbox(w3_rot[23:16]), sbox(w3_rot[15:8]), sbox(w3_rot[7:0])};
        o0     = ip_key[127:96] ^ t;
        o1     = ip_key[95:64] ^ o0;
        o2     = ip_key[63:32] ^ o1;
        o3     = ip_key[31:0] ^ o2;
        op_key = enable ? {o0, o1, o2, o3} : '0;
    end
endmodule

module key_expand_ctrl (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    output logic         busy,
    output logic         keys_valid,
    input  logic [3:0]   rk_idx,
`ifdef KEY_EXPAND_ZEROIZE_EN
    input  logic         zeroize,
`endif
    output logic [127:0] rk_out
);
    typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

    state_t       state_q, state_d;
    logic [3:0]   rnd_q, rnd_d;
    logic         kv_q, kv_d;
    logic [127:0] rk_q [0:10];
    logic [127:0] rk_out_q;
    logic [127:0] ks_ip, ks_op;
    logic [3:0]   ks_rnd, src_idx;
    logic         accept, zero;

`ifdef KEY_EXPAND_ZEROIZE_EN
    assign zero = zeroize;
`else
    assign zero = 1'b0;
`endif

    assign key_ready  = state_q != EXPAND;
    assign busy       = state_q == EXPAND;
    assign keys_valid = kv_q;
    assign rk_out     = rk_out_q;
    assign accept     = key_valid & key_ready;
    assign src_idx    = rnd_q - 4'd1;
    assign ks_ip      = busy ? rk_q[src_idx] : '0;
    assign ks_rnd     = busy ? rnd_q : 4'd0;

    KeySchedule_top u_ks (
        .ip_key (ks_ip),
        .enable (busy),
        .rndNo  (ks_rnd),
        .op_key (ks_op)
    );

    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        kv_d    = kv_q;
        if (zero) begin
            state_d = IDLE;
            rnd_d   = 4'd0;
            kv_d    = 1'b0;
        end else if (accept) begin
            state_d = EXPAND;
            rnd_d   = 4'd1;
            kv_d    = 1'b0;
        end else if (state_q == EXPAND) begin
            state_d = (rnd_q == 4'd10) ? READY : EXPAND;
            kv_d    = rnd_q == 4'd10;
            rnd_d   = (rnd_q == 4'd10) ? rnd_q : rnd_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rnd_q   <= 4'd0;
            kv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            kv_q    <= kv_d;
        end
    end

    // Non-blocking read of rk_q means a same-edge write is seen only on the following read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rk_q     <= '{default: '0};
            rk_out_q <= '0;
        end else if (zero) begin
            rk_q     <= '{default: '0};
            rk_out_q <= '0;
        end else begin
            if (accept) rk_q[0] <= key_in;
            if (busy) rk_q[rnd_q] <= ks_op;
            rk_out_q <= (rk_idx <= 4'd10) ? rk_q[rk_idx] : '0;
        end
    end
endmodule
